// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back L1 data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } dcache_state_e;

  localparam int WORD_W          = 32;
  localparam int OFFSET_W        = 2;
  localparam int BLOCK_W         = 128;
  localparam int NUM_BLOCKS_DEF  = 8;
  localparam int ADDR_W_DEF      = 30;
  localparam int INDEX_W         = $clog2(NUM_BLOCKS_DEF);
  localparam int TAG_W           = ADDR_W_DEF - INDEX_W - OFFSET_W;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [31:0] satInc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_ctrl_fsm.sv
// Miss-handling controller: IDLE -> (WRITEBACK ->) ALLOCATE -> IDLE, plus the
// registered L2 request strobes.
module dcache_ctrl_fsm
  import dcache_pkg::*;
(
  input  logic          clk,
  input  logic          proc_reset,
  input  logic          req_i,
  input  logic          hit_i,
  input  logic          victimDirty_i,
  input  logic          memReady_i,
  output dcache_state_e state_o,
  output logic          memRead_o,
  output logic          memWrite_o
);

  dcache_state_e state_q, state_d;
  logic          memRead_q, memWrite_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_i && !hit_i) begin
          state_d = victimDirty_i ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: if (memReady_i) state_d = ALLOCATE;
      ALLOCATE:  if (memReady_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they leave a flop cleanly.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q    <= IDLE;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      memRead_q  <= (state_d == ALLOCATE);
      memWrite_q <= (state_d == WRITEBACK);
    end
  end

  assign state_o    = state_q;
  assign memRead_o  = memRead_q;
  assign memWrite_o = memWrite_q;

endmodule

// File: rtl/l1_dcache_wb.sv
// Direct-mapped, write-back, write-allocate L1 data cache with block-wide L2 port.
// Define DCACHE_PERF_EN to add saturating perf_hits/perf_misses counters.
module l1_dcache_wb
  import dcache_pkg::*;
#(
  parameter int NUM_BLOCKS      = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int ADDR_W          = 30
) (
  input  logic                         clk,
  input  logic                         proc_reset,
  input  logic                         proc_read,
  input  logic                         proc_write,
  input  logic [ADDR_W-1:0]            proc_addr,
  input  logic [WORD_W-1:0]            proc_wdata,
  output logic [WORD_W-1:0]            proc_rdata,
  output logic                         proc_stall,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [ADDR_W-OFFSET_W-1:0]   mem_addr,
  output logic [WORDS_PER_BLOCK*WORD_W-1:0] mem_wdata,
  input  logic [WORDS_PER_BLOCK*WORD_W-1:0] mem_rdata,
  input  logic                         mem_ready
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]                  perf_hits,
  output logic [31:0]                  perf_misses
`endif
);

  localparam int IDX_W      = $clog2(NUM_BLOCKS);
  localparam int LINE_TAG_W = ADDR_W - IDX_W - OFFSET_W;
  localparam int LINE_W     = WORDS_PER_BLOCK * WORD_W;

  logic [OFFSET_W-1:0]   offset;
  logic [IDX_W-1:0]      index;
  logic [LINE_TAG_W-1:0] reqTag;

  logic [NUM_BLOCKS-1:0] lineValid_q, lineDirty_q;
  logic [LINE_TAG_W-1:0] lineTag_q  [NUM_BLOCKS];
  logic [LINE_W-1:0]     lineData_q [NUM_BLOCKS];

  logic          req, hit, victimDirty;
  logic          isIdle, wrHit, wbDone, fillDone;
  logic [WORD_W-1:0] selWord;
  dcache_state_e state;

  assign offset = proc_addr[OFFSET_W-1:0];
  assign index  = proc_addr[OFFSET_W +: IDX_W];
  assign reqTag = proc_addr[ADDR_W-1 -: LINE_TAG_W];

  assign req         = proc_read | proc_write;
  assign hit         = lineValid_q[index] && (lineTag_q[index] == reqTag);
  assign victimDirty = lineValid_q[index] && lineDirty_q[index];
  assign selWord     = lineData_q[index][offset*WORD_W +: WORD_W];

  assign isIdle   = (state == IDLE);
  assign wrHit    = isIdle && proc_write && hit;
  assign wbDone   = (state == WRITEBACK) && mem_ready;
  assign fillDone = (state == ALLOCATE) && mem_ready;

  dcache_ctrl_fsm u_ctrl (
    .clk           (clk),
    .proc_reset    (proc_reset),
    .req_i         (req),
    .hit_i         (hit),
    .victimDirty_i (victimDirty),
    .memReady_i    (mem_ready),
    .state_o       (state),
    .memRead_o     (mem_read),
    .memWrite_o    (mem_write)
  );

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      lineValid_q <= '0;
      lineDirty_q <= '0;
    end else begin
      if (fillDone) begin
        lineValid_q[index] <= 1'b1;
        lineDirty_q[index] <= 1'b0;
      end
      if (wbDone) lineDirty_q[index] <= 1'b0;
      if (wrHit)  lineDirty_q[index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (fillDone) begin
      lineData_q[index] <= mem_rdata;
      lineTag_q[index]  <= reqTag;
    end else if (wrHit) begin
      lineData_q[index][offset*WORD_W +: WORD_W] <= proc_wdata;
    end
  end

  always_comb begin
    proc_stall = 1'b1;
    proc_rdata = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        proc_stall = req && !hit;
        if (proc_read && hit) proc_rdata = selWord;
      end
      WRITEBACK: begin
        mem_addr  = {lineTag_q[index], index};
        mem_wdata = lineData_q[index];
      end
      ALLOCATE: mem_addr = {reqTag, index};
      default: ;
    endcase
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] perfHits_q, perfMisses_q;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      perfHits_q   <= '0;
      perfMisses_q <= '0;
    end else if (isIdle && req) begin
      if (hit) perfHits_q   <= satInc(perfHits_q);
      else     perfMisses_q <= satInc(perfMisses_q);
    end
  end

  assign perf_hits   = perfHits_q;
  assign perf_misses = perfMisses_q;
`endif

endmodule

// File: tb/tb_l1_dcache_wb.sv
// Self-checking bench for l1_dcache_wb: directed scenarios plus random traffic
// checked against a transaction-level cache/memory model.
module tb_l1_dcache_wb;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;
`ifdef DCACHE_PERF_EN
  logic [31:0]  perf_hits, perf_misses;
`endif

  int nCmp = 0;
  int nFail = 0;

  bit           mValid [8];
  bit           mDirty [8];
  logic [24:0]  mTag   [8];
  logic [127:0] mData  [8];
  logic [127:0] memModel [logic [27:0]];
  int unsigned  expHits, expMisses;

  always #5 clk = ~clk;

  l1_dcache_wb dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef DCACHE_PERF_EN
    ,
    .perf_hits  (perf_hits),
    .perf_misses(perf_misses)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCmp++;
    assert (act === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) begin
      mValid[i] = 1'b0;
      mDirty[i] = 1'b0;
    end
    expHits   = 0;
    expMisses = 0;
  endtask

  task automatic checkPerf();
`ifdef DCACHE_PERF_EN
    checkOutput("perfHits", perf_hits, expHits);
    checkOutput("perfMisses", perf_misses, expMisses);
`endif
  endtask

  // One processor access held until the cache accepts it; L2 answers after
  // dly cycles (negative dly picks a random latency).
  task automatic applyStimulus(input logic rd, input logic wr, input logic [29:0] a,
                               input logic [31:0] wd, input int dly);
    logic [2:0]   idx;
    logic [24:0]  tg;
    int           off;
    int           d;
    logic [27:0]  blkAddr;
    logic [127:0] blk;
    idx = a[4:2];
    tg  = a[29:5];
    off = int'(a[1:0]);
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = wd;
    #1;
    if (!(mValid[idx] && mTag[idx] == tg)) begin
      checkOutput("missStall", proc_stall, 1);
      expMisses++;
      tick();
      if (mDirty[idx]) begin
        blkAddr = {mTag[idx], idx};
        d = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
        for (int k = 0; k <= d; k++) begin
          checkOutput("wbMemWrite", mem_write, 1);
          checkOutput("wbMemRead", mem_read, 0);
          checkOutput("wbAddr", mem_addr, blkAddr);
          checkOutput("wbData", mem_wdata, mData[idx]);
          checkOutput("wbStall", proc_stall, 1);
          if (k == d) mem_ready = 1'b1;
          tick();
          mem_ready = 1'b0;
        end
        memModel[blkAddr] = mData[idx];
        mDirty[idx] = 1'b0;
      end
      blkAddr = {tg, idx};
      if (!memModel.exists(blkAddr)) memModel[blkAddr] = rand128();
      blk = memModel[blkAddr];
      d = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
      for (int k = 0; k <= d; k++) begin
        checkOutput("allocMemRead", mem_read, 1);
        checkOutput("allocMemWrite", mem_write, 0);
        checkOutput("allocAddr", mem_addr, blkAddr);
        checkOutput("allocStall", proc_stall, 1);
        if (k == d) begin
          mem_rdata = blk;
          mem_ready = 1'b1;
        end
        tick();
        mem_ready = 1'b0;
        mem_rdata = rand128();
      end
      mValid[idx] = 1'b1;
      mDirty[idx] = 1'b0;
      mTag[idx]   = tg;
      mData[idx]  = blk;
    end
    checkOutput("hitStall", proc_stall, 0);
    checkOutput("hitMemRead", mem_read, 0);
    checkOutput("hitMemWrite", mem_write, 0);
    checkOutput("rdata", proc_rdata, rd ? {96'd0, mData[idx][off*32 +: 32]} : 128'd0);
    expHits++;
    if (wr) begin
      mData[idx][off*32 +: 32] = wd;
      mDirty[idx] = 1'b1;
    end
    tick();
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  initial begin
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    modelReset();
    repeat (3) tick();
    proc_reset = 1'b0;
    #1;
    checkOutput("rstStall", proc_stall, 0);
    checkOutput("rstMemRead", mem_read, 0);
    checkOutput("rstMemWrite", mem_write, 0);
    checkOutput("rstMemAddr", mem_addr, 0);
    checkOutput("rstMemWdata", mem_wdata, 0);
    checkOutput("rstRdata", proc_rdata, 0);
    checkPerf();

    $display("[TB] cold read, write hit, conflict and clean eviction");
    memModel[28'h4] = {32'hD, 32'hC, 32'hB, 32'hA};
    applyStimulus(1'b1, 1'b0, 30'h10, 32'h0, 5);
    applyStimulus(1'b0, 1'b1, 30'h11, 32'h55, -1);
    applyStimulus(1'b1, 1'b0, 30'h11, 32'h0, -1);
    applyStimulus(1'b1, 1'b0, 30'h90, 32'h0, 3);
    applyStimulus(1'b1, 1'b0, 30'h10, 32'h0, 2);
    applyStimulus(1'b1, 1'b1, 30'h12, 32'h77, -1);
    checkPerf();

    $display("[TB] reset during refill");
    proc_read = 1'b1;
    proc_addr = 30'h2C;
    #1;
    checkOutput("preRstStall", proc_stall, 1);
    tick();
    checkOutput("preRstMemRead", mem_read, 1);
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    tick();
    proc_reset = 1'b0;
    modelReset();
    checkOutput("postRstMemRead", mem_read, 0);
    checkOutput("postRstMemWrite", mem_write, 0);
    checkOutput("postRstMemAddr", mem_addr, 0);
    checkOutput("postRstStall", proc_stall, 0);
    checkOutput("postRstRdata", proc_rdata, 0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checkOutput("strayReadyMemRead", mem_read, 0);
    checkOutput("strayReadyMemWrite", mem_write, 0);
    checkOutput("strayReadyStall", proc_stall, 0);
    checkPerf();
    applyStimulus(1'b1, 1'b0, 30'h10, 32'h0, -1);
    applyStimulus(1'b1, 1'b0, 30'h2C, 32'h0, -1);

    $display("[TB] random traffic");
    for (int n = 0; n < 80; n++) begin
      logic [29:0] a;
      int op;
      a  = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      op = int'($urandom_range(0, 2));
      applyStimulus(op != 1, op != 0, a, $urandom, -1);
      if ($urandom_range(0, 3) == 0) begin
        #1;
        checkOutput("idleStall", proc_stall, 0);
        checkOutput("idleRdata", proc_rdata, 0);
        tick();
      end
    end
    checkPerf();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
